// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round constants, GF(2^8) helpers and S-boxes.
package aes_pkg;

  typedef enum logic [2:0] {S_IDLE, S_KEY_EXP, S_INIT_ARK, S_ROUND, S_DONE} state_t;

  // Padded to 16 entries so a 4-bit counter can index it directly.
  localparam logic [7:0] RCON [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                         8'h40, 8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00,
                                         8'h00, 8'h00};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] e;
    e = a;
    for (int i = 0; i < 6; i++) e = gf_mul(gf_mul(e, e), a);
    return gf_mul(e, e);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] sub;
  logic [127:0] ark;
  logic [7:0]   a0, a1, a2, a3;

  // Byte index is 4*col+row; byte 0 sits in the top bits.
  always_comb begin
    sub = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    ark = sub ^ round_key;
  end

  always_comb begin
    next_state = ark;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = ark[127-32*c -: 8];
        a1 = ark[119-32*c -: 8];
        a2 = ark[111-32*c -: 8];
        a3 = ark[103-32*c -: 8];
        next_state[127-32*c -: 32] = {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                                      mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                                      mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3),
                                      mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3)};
      end
    end
  end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption: forward key expansion, then one inverse round per clock.
// Optional AES_DEC_KEY_CACHE_EN keeps the last key and its round-10 key to skip expansion.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         i_clock,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [0:127] i_cipher,
  input  logic [0:127] i_key,
  output logic [0:127] o_plain,
  output logic         o_busy,
  output logic         o_is_done
);

  state_t       state_q, state_d;
  logic [127:0] st_q, key_q, plain_q;
  logic [3:0]   cnt_q;
  logic [127:0] key_fwd, key_bwd, round_out, load_key;
  logic         accept, cache_hit;

  function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
    return sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ g_word(k[31:0], rc);
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one schedule step: the new w3 feeds the g-function for w0.
  function automatic logic [127:0] bwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ g_word(w3, rc);
    return {w0, w1, w2, w3};
  endfunction

  assign accept  = i_start && (state_q == S_IDLE || state_q == S_DONE);
  assign key_fwd = fwd_step(key_q, RCON[cnt_q]);
  assign key_bwd = bwd_step(key_q, RCON[cnt_q + 4'd1]);

  aes_inv_round u_round (
    .state      (st_q),
    .round_key  (key_bwd),
    .last       (cnt_q == 4'd0),
    .next_state (round_out)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key, cache_rk;
  logic         cache_vld;

  assign cache_hit = cache_vld && (cache_key == i_key);
  assign load_key  = cache_hit ? cache_rk : i_key;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cache_key <= '0;
      cache_rk  <= '0;
      cache_vld <= 1'b0;
    end else if (accept && !cache_hit) begin
      cache_key <= i_key;
      cache_vld <= 1'b0;
    end else if (state_q == S_KEY_EXP && cnt_q == 4'd10) begin
      cache_rk  <= key_fwd;
      cache_vld <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign load_key  = i_key;
`endif

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (accept) state_d = cache_hit ? S_INIT_ARK : S_KEY_EXP;
      S_KEY_EXP:      if (cnt_q == 4'd10) state_d = S_INIT_ARK;
      S_INIT_ARK:     state_d = S_ROUND;
      S_ROUND:        if (cnt_q == 4'd0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q    <= '0;
      key_q   <= '0;
      plain_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            st_q  <= i_cipher;
            key_q <= load_key;
            cnt_q <= 4'd1;
          end
        end
        S_KEY_EXP: begin
          key_q <= key_fwd;
          cnt_q <= cnt_q + 4'd1;
        end
        S_INIT_ARK: begin
          st_q  <= st_q ^ key_q;
          cnt_q <= 4'd9;
        end
        S_ROUND: begin
          st_q  <= round_out;
          key_q <= key_bwd;
          if (cnt_q == 4'd0) plain_q <= round_out;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_plain   = plain_q;
  assign o_busy    = (state_q == S_KEY_EXP) || (state_q == S_INIT_ARK) || (state_q == S_ROUND);
  assign o_is_done = (state_q == S_DONE);

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS-197 vectors plus random blocks encrypted by a reference AES model.
module tb_aes_decrypt;

  logic         i_clock = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [0:127] i_cipher, i_key;
  logic [0:127] o_plain;
  logic         o_busy, o_is_done;

  always #5 i_clock = ~i_clock;

  aes_decrypt dut (
    .i_clock   (i_clock),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_cipher  (i_cipher),
    .i_key     (i_key),
    .o_plain   (o_plain),
    .o_busy    (o_busy),
    .o_is_done (o_is_done)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC   = 128'h00112233445566778899aabbccddeeff;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sb [256];
  logic         cache_ok = 1'b0;
  logic [127:0] last_key = '0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int a = 1; a < 256; a++) if (m_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(a);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endfunction

  function automatic logic [127:0] m_round_key(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
            s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
          end
        end
      end
      rk = m_round_key(key, rnd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // One decryption; optional ignored start pulses carrying another ciphertext while busy.
  task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input bit pulse, input logic [127:0] other);
    bit hit;
    int lat;
    hit = CACHE_EN && cache_ok && (key == last_key);
    lat = 0;
    @(negedge i_clock);
    i_start  = 1'b1;
    i_cipher = ct;
    i_key    = key;
    @(posedge i_clock);
    #1;
    i_start  = 1'b0;
    i_cipher = {$urandom, $urandom, $urandom, $urandom};
    i_key    = {$urandom, $urandom, $urandom, $urandom};
    check_val({tag, "_busy_e0"}, 128'(o_busy), 128'd1);
    check_val({tag, "_done_e0"}, 128'(o_is_done), 128'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_clock);
      #1;
      if (c == 10 && !hit) check_val({tag, "_rk10"}, dut.key_q, m_round_key(key, 10));
      if (pulse && (c == 5 || c == 10)) begin
        i_start  = 1'b1;
        i_cipher = other;
      end else begin
        i_start = 1'b0;
      end
      if (o_is_done) begin
        lat = c;
        break;
      end
    end
    i_start = 1'b0;
    check_val({tag, "_latency"}, 128'(lat), hit ? 128'd11 : 128'd21);
    check_val({tag, "_plain"}, o_plain, pt);
    check_val({tag, "_busy_end"}, 128'(o_busy), 128'd0);
    if (!hit) last_key = key;
    cache_ok = (lat != 0);
  endtask

  initial begin
    logic [127:0] k, p;
    int first, second;
    build_sbox();
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    i_cipher = '0;
    i_key    = '0;
    repeat (3) @(posedge i_clock);
    #1;
    check_val("rst_plain", o_plain, 128'd0);
    check_val("rst_busy", 128'(o_busy), 128'd0);
    check_val("rst_done", 128'(o_is_done), 128'd0);
    @(negedge i_clock);
    i_rst_n = 1'b1;

    check_val("model_appB", m_encrypt(KB, PB), CB);
    check_val("model_rk10", m_round_key(KB, 10), RK10);

    run_block("appB", KB, CB, PB, 1'b0, '0);
    run_block("appC", KC, CC, PC, 1'b0, '0);
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rand%0d", n), k, m_encrypt(k, p), p, 1'b0, '0);
    end
    run_block("busy", KC, CC, PC, 1'b1, CB);

    // Reset in the middle of a run.
    @(negedge i_clock);
    i_start  = 1'b1;
    i_cipher = CB;
    i_key    = KB;
    @(posedge i_clock);
    #1;
    i_start = 1'b0;
    repeat (15) @(posedge i_clock);
    #1;
    i_rst_n = 1'b0;
    #1;
    check_val("midrst_plain", o_plain, 128'd0);
    check_val("midrst_busy", 128'(o_busy), 128'd0);
    check_val("midrst_done", 128'(o_is_done), 128'd0);
    @(negedge i_clock);
    i_rst_n  = 1'b1;
    cache_ok = 1'b0;
    run_block("post_rst", KC, CC, PC, 1'b0, '0);

    // Back-to-back with start held high.
    first  = 0;
    second = 0;
    @(negedge i_clock);
    i_start  = 1'b1;
    i_cipher = CB;
    i_key    = KB;
    @(posedge i_clock);
    #1;
    i_cipher = CC;
    i_key    = KC;
    for (int c = 1; c <= 60; c++) begin
      @(posedge i_clock);
      #1;
      if (first == 0) begin
        if (o_is_done) begin
          first = c;
          check_val("b2b_plain1", o_plain, PB);
        end
      end else if (c == first + 1) begin
        check_val("b2b_drop", 128'(o_is_done), 128'd0);
      end else if (o_is_done) begin
        second = c;
        check_val("b2b_plain2", o_plain, PC);
        break;
      end
    end
    i_start = 1'b0;
    check_val("b2b_first", 128'(first), 128'd21);
    check_val("b2b_gap", 128'(second - first), 128'd22);
    last_key = KC;
    cache_ok = (second != 0);

    run_block("repeat_keyC", KC, CC, PC, 1'b0, '0);
    run_block("change_keyB", KB, CB, PB, 1'b0, '0);
    run_block("repeat_keyB", KB, CB, PB, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
